apb_mem_bus_sequencer: RTL and testbench

Owns the shared APB memory bus behind the per-port request FIFOs. It picks one pending FIFO head per transaction with a round-robin policy and pops that FIFO. It then drives the APB master SETUP/ACCESS phases to memory, waits on PREADY with a bounded timeout, and returns read data, error and requester ID to the response demux. It replaces the separate grant logic and the free-running master glue with one sequenced controller.

---
 rtl/apb_mem_bus_sequencer_pkg.sv | 31 +++
 rtl/apb_mem_bus_sequencer_if.sv | 46 ++++
 rtl/apb_mem_bus_sequencer_rr_pick.sv | 35 +++
 rtl/apb_mem_bus_sequencer.sv | 119 +++++++++++
 tb/tb_apb_mem_bus_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_mem_bus_sequencer_pkg.sv
// Shared types for the APB memory interconnect: packet layout, sequencer states, RR helper.
// No logic; latency n/a; backpressure n/a.
package apb_ic_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int ID_W        = $clog2(DEF_NUM_REQ);

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic                  write;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } seq_state_e;

    // (base + ofs) mod n, valid while base < n and ofs < n
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned ofs,
                                            input int unsigned n);
        int unsigned s;
        s = base + ofs;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/apb_mem_bus_sequencer_if.sv
// Requester-FIFO heads, APB master bus and response channel of the memory sequencer.
// Wires only; latency n/a; backpressure via req/gnt pop strobe and APB PREADY.
interface apb_mem_bus_sequencer_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int RID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        gnt;

    logic                      PSEL;
    logic                      PENABLE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PWRITE;
    logic                      PREADY;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PSLVERR;

    logic                      rsp_valid;
    logic [RID_W-1:0]          rsp_id;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    modport master (
        input  req, req_addr, req_wdata, req_write,
        output gnt,
        output PSEL, PENABLE, PADDR, PWDATA, PWRITE,
        input  PREADY, PRDATA, PSLVERR,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err
    );

    modport slave (
        output req, req_addr, req_wdata, req_write,
        input  gnt,
        input  PSEL, PENABLE, PADDR, PWDATA, PWRITE,
        output PREADY, PRDATA, PSLVERR,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/apb_mem_bus_sequencer_rr_pick.sv
// Round-robin picker: first set req bit at or above ptr, wrapping; one-hot and index out.
// Combinational, zero latency; no backpressure (vld=0 when nothing requests).
module rr_pick
    import apb_ic_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         vld
);

    logic [W-1:0] pos [N];

    for (genvar i = 0; i < N; i++) begin : g_pos
        assign pos[i] = W'(rr_wrap(32'(ptr), i, N));
    end

    always_comb begin
        onehot = '0;
        idx    = '0;
        vld    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!vld && req[pos[i]]) begin
                vld            = 1'b1;
                onehot[pos[i]] = 1'b1;
                idx            = pos[i];
            end
        end
    end

endmodule

// File: rtl/apb_mem_bus_sequencer.sv
// Round-robin pops one requester FIFO head and runs it as an APB SETUP/ACCESS transfer.
// Zero-wait: gnt N, PSEL N+1, PENABLE N+2, rsp_valid N+3; ACCESS aborts after TIMEOUT cycles.
// Backpressure: no grant outside IDLE/completing ACCESS; memory stalls via PREADY; rsp never stalls.
module apb_mem_bus_sequencer
    import apb_ic_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    apb_mem_bus_sequencer_if.master   bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    seq_state_e         state, state_nxt;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_vld;
    logic [CW-1:0]      cnt;
    logic               done;
    logic               arb;
    logic               take;

    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic               lat_write;
    logic [IW-1:0]      lat_id;

    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic [IW-1:0]      rsp_id_q;

    rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .vld    (win_vld)
    );

    // Completion is either the memory answering or the wait budget running out.
    assign done = (state == ACCESS) && (bus.PREADY || (cnt == CW'(TIMEOUT - 1)));
    assign arb  = (state == IDLE) || done;
    assign take = arb && win_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.gnt     = '0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        case (state)
            IDLE:    if (win_vld) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = win_vld ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
        // Pop strobe is held off while reset is asserted so no FIFO drains during reset.
        if (take && reset) bus.gnt = win_oh;
        bus.PSEL    = (state == SETUP) || (state == ACCESS);
        bus.PENABLE = (state == ACCESS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_write   <= 1'b0;
            lat_id      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_id_q    <= '0;
        end else begin
            if (take) begin
                lat_addr  <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                lat_wdata <= bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                lat_write <= bus.req_write[win_idx];
                lat_id    <= win_idx;
                ptr       <= IW'(rr_wrap(32'(win_idx), 1, NUM_REQ));
                cnt       <= '0;
            end else if ((state == ACCESS) && !done) begin
                cnt <= cnt + 1'b1;
            end

            rsp_valid_q <= done;
            if (done) begin
                rsp_id_q    <= lat_id;
                rsp_err_q   <= bus.PREADY ? bus.PSLVERR : 1'b1;
                rsp_rdata_q <= (bus.PREADY && !bus.PSLVERR && !lat_write) ? bus.PRDATA : '0;
            end else begin
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign bus.PADDR     = lat_addr;
    assign bus.PWDATA    = lat_wdata;
    assign bus.PWRITE    = lat_write;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_apb_mem_bus_sequencer.sv
// Vector table of grants with an APB memory responder and a response scoreboard.
module tb_apb_mem_bus_sequencer;

    localparam int NR    = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TO    = 16;
    localparam int WT_TO = 255;
    localparam int NV    = 14;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apb_mem_bus_sequencer_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();

    apb_mem_bus_sequencer #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  add;
        bit          keep;
        int          win;
        bit          write;
        int          waits;
        bit          err;
        logic [31:0] rdata;
        int          gap;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          write;
        int          waits;
        bit          err;
        logic [31:0] rdata;
    } slv_t;

    typedef struct {
        int          id;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    vec_t        vt [NV];
    slv_t        slv_q [$];
    exp_t        exp_q [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_gnt = 0;
    logic [3:0]  req_r;
    logic [31:0] h_addr [NR];
    logic [31:0] h_wdata [NR];
    bit          h_write;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    task automatic drive_heads(input int v, input bit wr);
        for (int i = 0; i < NR; i++) begin
            h_addr[i]  = 32'h10 + (32'(v) << 8) + (32'(i) << 4);
            h_wdata[i] = 32'hC0DE0000 ^ h_addr[i];
            bus.req_addr[i*AW +: AW]  = h_addr[i];
            bus.req_wdata[i*DW +: DW] = h_wdata[i];
        end
        h_write       = wr;
        bus.req_write = {NR{wr}};
        bus.req       = req_r;
    endtask

    // Called just after a falling edge; returns on the falling edge after the grant.
    task automatic do_grant(input int win, input bit keep, input int waits, input bit err,
                            input logic [31:0] rdata, input int gap, input bit push_exp);
        bit   got;
        slv_t s;
        exp_t e;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (bus.gnt != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("grant", {60'd0, bus.gnt}, 64'(1) << win);
        if (got && gap != 0) chk("grant_gap", 64'(cyc - last_gnt), 64'(gap));
        last_gnt = cyc;
        s.addr  = h_addr[win];
        s.wdata = h_wdata[win];
        s.write = h_write;
        s.waits = waits;
        s.err   = err;
        s.rdata = rdata;
        slv_q.push_back(s);
        if (push_exp) begin
            e.id    = win;
            e.err   = (waits == WT_TO) ? 1'b1 : err;
            e.rdata = (waits != WT_TO && !err && !h_write) ? rdata : 32'h0;
            e.cyc   = cyc + ((waits == WT_TO) ? 2 + TO : 3 + waits);
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (!keep) req_r[win] = 1'b0;
        bus.req = req_r;
    endtask

    // APB memory responder: decides PREADY for each ACCESS cycle from the popped transfer.
    initial begin
        slv_t cur;
        int   acc;
        acc          = 0;
        cur          = '{32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0};
        bus.PREADY   = 1'b0;
        bus.PSLVERR  = 1'b0;
        bus.PRDATA   = '0;
        forever begin
            @(negedge clk);
            chk("penable_needs_psel", {63'd0, bus.PENABLE & ~bus.PSEL}, 64'd0);
            chk("gnt_onehot0", {63'd0, $onehot0(bus.gnt)}, 64'd1);
            if (!reset) begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                acc         = 0;
            end else if (bus.PSEL && !bus.PENABLE) begin
                if (slv_q.size() == 0) fail_now("setup_without_grant");
                else cur = slv_q.pop_front();
                acc         = 0;
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                chk("setup_paddr", bus.PADDR, cur.addr);
                chk("setup_pwdata", bus.PWDATA, cur.wdata);
                chk("setup_pwrite", bus.PWRITE, cur.write);
            end else if (bus.PSEL && bus.PENABLE) begin
                chk("access_paddr_hold", bus.PADDR, cur.addr);
                chk("access_pwdata_hold", bus.PWDATA, cur.wdata);
                chk("access_pwrite_hold", bus.PWRITE, cur.write);
                if (cur.waits != WT_TO && acc == cur.waits) begin
                    bus.PREADY  = 1'b1;
                    bus.PSLVERR = cur.err;
                    bus.PRDATA  = cur.rdata;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PSLVERR = 1'b0;
                    bus.PRDATA  = 32'h5A5A0000 | 32'(acc);
                end
                acc++;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
            end
        end
    end

    // Response scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_err", bus.rsp_err, e.err);
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        //          add      keep  win wr  waits  err  rdata           gap
        vt[0]  = '{4'b0001, 1'b0, 0, 1'b0, 0,     1'b0, 32'hDEADBEEF, 0};
        vt[1]  = '{4'b1000, 1'b0, 3, 1'b0, 0,     1'b0, 32'h11111111, 2};
        vt[2]  = '{4'b1001, 1'b0, 0, 1'b0, 0,     1'b0, 32'h22222222, 2};
        vt[3]  = '{4'b0011, 1'b0, 1, 1'b0, 0,     1'b0, 32'h33333333, 2};
        vt[4]  = '{4'b0000, 1'b0, 3, 1'b0, 0,     1'b0, 32'h44444444, 2};
        vt[5]  = '{4'b1111, 1'b1, 0, 1'b0, 0,     1'b0, 32'h50505050, 2};
        vt[6]  = '{4'b0000, 1'b1, 1, 1'b0, 0,     1'b0, 32'h61616161, 2};
        vt[7]  = '{4'b0000, 1'b1, 2, 1'b0, 0,     1'b0, 32'h72727272, 2};
        vt[8]  = '{4'b0000, 1'b1, 3, 1'b0, 0,     1'b0, 32'h83838383, 2};
        vt[9]  = '{4'b0000, 1'b1, 0, 1'b0, 0,     1'b0, 32'h90909090, 2};
        vt[10] = '{4'b0000, 1'b0, 1, 1'b1, 3,     1'b1, 32'hFFFF0000, 2};
        vt[11] = '{4'b0000, 1'b0, 2, 1'b0, WT_TO, 1'b0, 32'hBADBAD00, 5};
        vt[12] = '{4'b0000, 1'b0, 3, 1'b0, 1,     1'b0, 32'h12345678, 17};
        vt[13] = '{4'b0000, 1'b0, 0, 1'b0, 2,     1'b1, 32'hA5A5A5A5, 3};

        reset = 1'b0;
        req_r = 4'b1111;
        drive_heads(99, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_psel", bus.PSEL, 1'b0);
        chk("reset_penable", bus.PENABLE, 1'b0);
        chk("reset_gnt", bus.gnt, 4'b0000);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rsp_err", bus.rsp_err, 1'b0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("reset_rsp_id", bus.rsp_id, 2'd0);
        chk("reset_paddr", bus.PADDR, 32'h0);
        chk("reset_pwdata", bus.PWDATA, 32'h0);
        chk("reset_pwrite", bus.PWRITE, 1'b0);

        @(negedge clk);
        req_r   = 4'b0000;
        bus.req = req_r;
        reset   = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            req_r = req_r | vt[v].add;
            drive_heads(v, vt[v].write);
            do_grant(vt[v].win, vt[v].keep, vt[v].waits, vt[v].err, vt[v].rdata, vt[v].gap, 1'b1);
        end

        // Reset mid-ACCESS drops the transfer and restarts the pointer at 0.
        req_r = req_r | 4'b0100;
        drive_heads(20, 1'b0);
        do_grant(2, 1'b0, WT_TO, 1'b0, 32'h0, 0, 1'b0);
        repeat (2) @(negedge clk);
        req_r = 4'b1100;
        drive_heads(21, 1'b0);
        reset = 1'b0;
        #1;
        chk("midreset_psel", bus.PSEL, 1'b0);
        chk("midreset_penable", bus.PENABLE, 1'b0);
        chk("midreset_gnt", bus.gnt, 4'b0000);
        repeat (2) @(negedge clk);
        chk("midreset_rsp_valid", bus.rsp_valid, 1'b0);
        reset = 1'b1;
        do_grant(2, 1'b0, 0, 1'b0, 32'h13579BDF, 0, 1'b1);
        do_grant(3, 1'b0, 0, 1'b0, 32'h2468ACE0, 2, 1'b1);

        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        chk("drain_rsp", 64'(exp_q.size()), 64'd0);
        chk("drain_slave", 64'(slv_q.size()), 64'd0);
        chk("idle_psel", bus.PSEL, 1'b0);
        chk("idle_gnt", bus.gnt, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
